// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 3-stage FP32 multiplier (classify / multiply / normalise+pack)
// with valid/ready handshakes, truncating rounding and flush-to-zero subnormals.
module fp_mul_pipe #(
  parameter int TAG_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_fp1,
  input  logic [31:0]      i_fp2,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_fp,
  output logic [TAG_W-1:0] o_tag
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic w_adv;

  // Stage 1 registers: classification, exponent sum, significands
  logic                    r_v1, r_s1, r_nan1, r_inf1, r_zero1;
  logic signed [9:0]       r_es1;
  logic [23:0]             r_siga, r_sigb;
  logic [TAG_W-1:0]        r_tag1;

  // Stage 2 registers: raw 48-bit product
  logic                    r_v2, r_s2, r_nan2, r_inf2, r_zero2;
  logic signed [9:0]       r_es2;
  logic [47:0]             r_prod;
  logic [TAG_W-1:0]        r_tag2;

  // Stage 3 registers: packed result
  logic                    r_v3;
  logic [31:0]             r_fp;
  logic [TAG_W-1:0]        r_tag;

  logic [7:0]              w_e1, w_e2;
  logic                    w_inf1, w_inf2, w_zero1, w_zero2;
  logic signed [9:0]       w_es;
  logic [47:0]             w_prod;
  logic signed [9:0]       w_e;
  logic [22:0]             w_man;
  logic [31:0]             w_fp;

  // A single advance signal stalls the whole pipe only when the output is held.
  assign w_adv   = ~r_v3 | i_ready;
  assign o_ready = w_adv;
  assign o_valid = r_v3;
  assign o_fp    = r_fp;
  assign o_tag   = r_tag;

  assign w_e1    = i_fp1[30:23];
  assign w_e2    = i_fp2[30:23];
  assign w_inf1  = (w_e1 == 8'hFF);
  assign w_inf2  = (w_e2 == 8'hFF);
  assign w_zero1 = (w_e1 == 8'h00);
  assign w_zero2 = (w_e2 == 8'h00);
  assign w_es    = $signed({2'b00, w_e1}) + $signed({2'b00, w_e2}) - 10'sd127;

  assign w_prod  = {24'h0, r_siga} * {24'h0, r_sigb};

  assign w_e     = r_prod[47] ? (r_es2 + 10'sd1) : r_es2;
  assign w_man   = r_prod[47] ? r_prod[46:24] : r_prod[45:23];

  // NOTE: every output of an always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_fp = {r_s2, w_e[7:0], w_man};
    if (r_nan2)                w_fp = QNAN;
    else if (r_inf2)           w_fp = {r_s2, 8'hFF, 23'h0};
    else if (r_zero2)          w_fp = {r_s2, 31'h0};
    else if (w_e >= 10'sd255)  w_fp = {r_s2, 8'hFF, 23'h0};
    else if (w_e <= 10'sd0)    w_fp = {r_s2, 31'h0};
  end

  // NOTE: sequential state uses non-blocking assignments so all stages shift on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_v3  <= 1'b0;
      r_fp  <= 32'h0;
      r_tag <= '0;
    end else if (w_adv) begin
      r_v1  <= i_valid;
      r_v2  <= r_v1;
      r_v3  <= r_v2;
      r_fp  <= w_fp;
      r_tag <= r_tag2;
    end
  end

  // NOTE: internal datapath registers are not reset; their stage valid bit qualifies them.
  always_ff @(posedge i_clk) begin
    if (w_adv) begin
      r_s1    <= i_fp1[31] ^ i_fp2[31];
      r_nan1  <= (w_inf1 | w_inf2) & (w_zero1 | w_zero2);
      r_inf1  <= w_inf1 | w_inf2;
      r_zero1 <= w_zero1 | w_zero2;
      r_es1   <= w_es;
      r_siga  <= {1'b1, i_fp1[22:0]};
      r_sigb  <= {1'b1, i_fp2[22:0]};
      r_tag1  <= i_tag;

      r_s2    <= r_s1;
      r_nan2  <= r_nan1;
      r_inf2  <= r_inf1;
      r_zero2 <= r_zero1;
      r_es2   <= r_es1;
      r_prod  <= w_prod;
      r_tag2  <= r_tag1;
    end
  end

endmodule
